// File: rtl/sunrise_sequencer.sv
// sunrise_sequencer: frame-rate day/night controller for the sun overlay.
// Walks IDLE -> RISE -> HOLD_DAY -> FALL -> HOLD_NIGHT and drives the
// overlay's fade_level/direction. Every output comes from a register and
// only moves on frame ticks (or abort/start/reset), so the overlay never
// sees a mid-frame change.
//
// Control semantics: frame is a one-cycle pulse per frame; a tick is
// frame & run_en. Priority is abort, then start (IDLE only), then tick.
// run_en=0 freezes state and both counters; cycle_done is always a
// single-cycle pulse, raised in the cycle after HOLD_NIGHT expires.
module sunrise_sequencer #(
    parameter int FRAMES_PER_STEP = 2,
    parameter int HOLD_FRAMES     = 60
) (
    input  logic       clk_pix,
    input  logic       rst,
    input  logic       frame,
    input  logic       start,
    input  logic       abort,
    input  logic       run_en,
    input  logic       loop,
    output logic [7:0] fade_level,
    output logic       direction,
    output logic [2:0] phase,
    output logic       cycle_done
);

    // Phase encodings; also exported on `phase` as the FSM debug view.
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RISE       = 3'd1;
    localparam logic [2:0] S_HOLD_DAY   = 3'd2;
    localparam logic [2:0] S_FALL       = 3'd3;
    localparam logic [2:0] S_HOLD_NIGHT = 3'd4;

    // Terminal counts for the 16-bit prescale and hold counters.
    localparam logic [15:0] STEP_LAST = 16'(FRAMES_PER_STEP - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);

    logic [2:0]  state;
    logic [15:0] step_cnt;
    logic [15:0] hold_cnt;
    logic        tick;

    assign tick  = frame & run_en;
    assign phase = state;

    // Main sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            step_cnt   <= 16'd0;
            hold_cnt   <= 16'd0;
            fade_level <= 8'd0;
            direction  <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (abort) begin
                state      <= S_IDLE;
                step_cnt   <= 16'd0;
                hold_cnt   <= 16'd0;
                fade_level <= 8'd0;
                direction  <= 1'b0;
            end else if (start && (state == S_IDLE)) begin
                // A tick coinciding with start is deliberately not counted.
                state      <= S_RISE;
                step_cnt   <= 16'd0;
                hold_cnt   <= 16'd0;
                fade_level <= 8'd0;
                direction  <= 1'b0;
            end else if (tick) begin
                case (state)
                    S_IDLE: begin
                        fade_level <= 8'd0;
                    end
                    S_RISE: begin
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= 16'd0;
                            if (fade_level != 8'd255) begin
                                fade_level <= fade_level + 8'd1;
                            end
                            // The step that lands on 255 also enters the hold.
                            if (fade_level >= 8'd254) begin
                                state    <= S_HOLD_DAY;
                                hold_cnt <= 16'd0;
                            end
                        end else begin
                            step_cnt <= step_cnt + 16'd1;
                        end
                    end
                    S_HOLD_DAY: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state     <= S_FALL;
                            hold_cnt  <= 16'd0;
                            step_cnt  <= 16'd0;
                            direction <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 16'd1;
                        end
                    end
                    S_FALL: begin
                        if (step_cnt == STEP_LAST) begin
                            step_cnt <= 16'd0;
                            if (fade_level != 8'd0) begin
                                fade_level <= fade_level - 8'd1;
                            end
                            // The step that lands on 0 also enters the hold.
                            if (fade_level <= 8'd1) begin
                                state    <= S_HOLD_NIGHT;
                                hold_cnt <= 16'd0;
                            end
                        end else begin
                            step_cnt <= step_cnt + 16'd1;
                        end
                    end
                    S_HOLD_NIGHT: begin
                        if (hold_cnt == HOLD_LAST) begin
                            cycle_done <= 1'b1;
                            state      <= loop ? S_RISE : S_IDLE;
                            step_cnt   <= 16'd0;
                            hold_cnt   <= 16'd0;
                            fade_level <= 8'd0;
                            direction  <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state      <= S_IDLE;
                        step_cnt   <= 16'd0;
                        hold_cnt   <= 16'd0;
                        fade_level <= 8'd0;
                        direction  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sunrise_sequencer.sv
// tb_sunrise_sequencer: directed bench for sunrise_sequencer.
// Two instances share stimulus: dut_a (P=1, H=4) for full-cycle ramps and
// dut_b (P=3, H=2) for prescale behaviour. Expected values are pushed to a
// scoreboard queue as stimulus is driven and popped when outputs are sampled.
module tb_sunrise_sequencer;

    logic       clk_pix;
    logic       rst;
    logic       frame;
    logic       start;
    logic       abort;
    logic       run_en;
    logic       loop;

    logic [7:0] a_fade;
    logic       a_dir;
    logic [2:0] a_phase;
    logic       a_done;
    logic [7:0] b_fade;
    logic       b_dir;
    logic [2:0] b_phase;
    logic       b_done;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    int          pass_cnt;
    int          total_cnt;

    sunrise_sequencer #(.FRAMES_PER_STEP(1), .HOLD_FRAMES(4)) dut_a (
        .clk_pix    (clk_pix),
        .rst        (rst),
        .frame      (frame),
        .start      (start),
        .abort      (abort),
        .run_en     (run_en),
        .loop       (loop),
        .fade_level (a_fade),
        .direction  (a_dir),
        .phase      (a_phase),
        .cycle_done (a_done)
    );

    sunrise_sequencer #(.FRAMES_PER_STEP(3), .HOLD_FRAMES(2)) dut_b (
        .clk_pix    (clk_pix),
        .rst        (rst),
        .frame      (frame),
        .start      (start),
        .abort      (abort),
        .run_en     (run_en),
        .loop       (loop),
        .fade_level (b_fade),
        .direction  (b_dir),
        .phase      (b_phase),
        .cycle_done (b_done)
    );

    // Clock generation: 10 time-unit period.
    initial begin
        clk_pix = 1'b0;
        forever #5 clk_pix = ~clk_pix;
    end

    // Advance one clock; outputs are sampled 1 unit after the rising edge.
    task automatic cyc();
        @(posedge clk_pix);
        #1;
    endtask

    // Record an expectation at the moment the stimulus is driven.
    task automatic sb_push(input string tag, input logic [15:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    // Pop the oldest expectation and compare it with the sampled output.
    task automatic sb_check(input logic [15:0] obs);
        logic [15:0] exp;
        string       tag;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $error("FAIL sb_underflow observed=%0h required=<queued expectation>", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            total_cnt++;
            assert (obs === exp) begin
                pass_cnt++;
            end else begin
                $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
            end
        end
    endtask

    // n frames: one-cycle frame pulse followed by one quiet cycle.
    task automatic tick_frames(input int n);
        repeat (n) begin
            frame = 1'b1;
            cyc();
            frame = 1'b0;
            cyc();
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst    = 1'b1;
        frame  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        run_en = 1'b1;
        loop   = 1'b1;

        // Reset values
        repeat (2) cyc();
        sb_push("rst_fade", 16'd0);    sb_check(16'(a_fade));
        sb_push("rst_phase", 16'd0);   sb_check(16'(a_phase));
        sb_push("rst_dir", 16'd0);     sb_check(16'(a_dir));
        sb_push("rst_done", 16'd0);    sb_check(16'(a_done));
        rst = 1'b0;
        cyc();

        // Idle: frames without start change nothing
        sb_push("idle_fade", 16'd0);
        sb_push("idle_phase", 16'd0);
        tick_frames(100);
        sb_check(16'(a_fade));
        sb_check(16'(a_phase));

        // start and frame together in IDLE: RISE, the tick is not counted
        start = 1'b1;
        frame = 1'b1;
        sb_push("start_tick_phase", 16'd1);
        sb_push("start_tick_fade", 16'd0);
        cyc();
        start = 1'b0;
        frame = 1'b0;
        cyc();
        sb_check(16'(a_phase));
        sb_check(16'(a_fade));

        // Prescale P=3: 2 ticks -> still 0 (step_cnt began at 0), 6 ticks -> 2
        sb_push("pre_b_2tick", 16'd0);
        tick_frames(2);
        sb_check(16'(b_fade));
        sb_push("pre_b_6tick", 16'd2);
        sb_push("pre_a_6tick", 16'd6);
        tick_frames(4);
        sb_check(16'(b_fade));
        sb_check(16'(a_fade));

        // run_en=0 freezes fade_level and step_cnt
        run_en = 1'b0;
        sb_push("freeze_b", 16'd2);
        sb_push("freeze_a", 16'd6);
        tick_frames(10);
        sb_check(16'(b_fade));
        sb_check(16'(a_fade));
        run_en = 1'b1;
        sb_push("thaw_b_2tick", 16'd2);
        tick_frames(2);
        sb_check(16'(b_fade));
        sb_push("thaw_b_3tick", 16'd3);
        sb_push("thaw_a_9tick", 16'd9);
        tick_frames(1);
        sb_check(16'(b_fade));
        sb_check(16'(a_fade));

        // Ramp up one step per frame, never more than one change per frame
        for (int i = 10; i <= 254; i++) begin
            sb_push("rise_step", 16'(i));
            tick_frames(1);
            sb_check(16'(a_fade));
        end
        sb_push("rise_254_phase", 16'd1);
        sb_check(16'(a_phase));
        sb_push("rise_top_fade", 16'd255);
        sb_push("rise_top_phase", 16'd2);
        sb_push("rise_top_dir", 16'd0);
        sb_push("b_at_255", 16'd85);
        tick_frames(1);
        sb_check(16'(a_fade));
        sb_check(16'(a_phase));
        sb_check(16'(a_dir));
        sb_check(16'(b_fade));

        // Day hold: H=4 ticks
        sb_push("hold_day_phase", 16'd2);
        sb_push("hold_day_fade", 16'd255);
        tick_frames(3);
        sb_check(16'(a_phase));
        sb_check(16'(a_fade));
        sb_push("fall_phase", 16'd3);
        sb_push("fall_dir", 16'd1);
        sb_push("fall_fade", 16'd255);
        sb_push("b_at_259", 16'd86);
        tick_frames(1);
        sb_check(16'(a_phase));
        sb_check(16'(a_dir));
        sb_check(16'(a_fade));
        sb_check(16'(b_fade));

        // start during FALL is ignored
        sb_push("start_in_fall", 16'd3);
        start_pulse();
        sb_check(16'(a_phase));

        // Ramp down
        for (int i = 254; i >= 1; i--) begin
            sb_push("fall_step", 16'(i));
            tick_frames(1);
            sb_check(16'(a_fade));
        end
        sb_push("night_fade", 16'd0);
        sb_push("night_phase", 16'd4);
        sb_push("night_dir", 16'd1);
        sb_push("b_at_514", 16'd171);
        tick_frames(1);
        sb_check(16'(a_fade));
        sb_check(16'(a_phase));
        sb_check(16'(a_dir));
        sb_check(16'(b_fade));

        // Night hold with loop=1: restart RISE, one-cycle cycle_done
        loop = 1'b1;
        sb_push("night_hold_phase", 16'd4);
        sb_push("night_hold_done", 16'd0);
        tick_frames(3);
        sb_check(16'(a_phase));
        sb_check(16'(a_done));
        frame = 1'b1;
        sb_push("loop_done_hi", 16'd1);
        sb_push("loop_phase", 16'd1);
        sb_push("loop_dir", 16'd0);
        sb_push("loop_fade", 16'd0);
        cyc();
        frame = 1'b0;
        sb_check(16'(a_done));
        sb_check(16'(a_phase));
        sb_check(16'(a_dir));
        sb_check(16'(a_fade));
        sb_push("loop_done_lo", 16'd0);
        cyc();
        sb_check(16'(a_done));

        // Second cycle with loop=0: ends in IDLE
        loop = 1'b0;
        sb_push("c2_day", 16'd2);
        tick_frames(255);
        sb_check(16'(a_phase));
        sb_push("c2_fall", 16'd3);
        tick_frames(4);
        sb_check(16'(a_phase));
        sb_push("c2_night", 16'd4);
        tick_frames(255);
        sb_check(16'(a_phase));
        tick_frames(3);
        frame = 1'b1;
        sb_push("noloop_done", 16'd1);
        sb_push("noloop_phase", 16'd0);
        sb_push("noloop_fade", 16'd0);
        sb_push("noloop_dir", 16'd0);
        cyc();
        frame = 1'b0;
        sb_check(16'(a_done));
        sb_check(16'(a_phase));
        sb_check(16'(a_fade));
        sb_check(16'(a_dir));
        cyc();
        sb_push("noloop_stays_idle", 16'd0);
        tick_frames(1);
        sb_check(16'(a_phase));
        sb_push("restart_phase", 16'd1);
        start_pulse();
        sb_check(16'(a_phase));

        // abort together with frame in HOLD_DAY
        tick_frames(255);
        sb_push("pre_abort_phase", 16'd2);
        sb_check(16'(a_phase));
        tick_frames(1);
        abort = 1'b1;
        frame = 1'b1;
        sb_push("abort_phase", 16'd0);
        sb_push("abort_fade", 16'd0);
        sb_push("abort_done", 16'd0);
        sb_push("abort_dir", 16'd0);
        sb_push("abort_b_phase", 16'd0);
        cyc();
        abort = 1'b0;
        frame = 1'b0;
        sb_check(16'(a_phase));
        sb_check(16'(a_fade));
        sb_check(16'(a_done));
        sb_check(16'(a_dir));
        sb_check(16'(b_phase));
        cyc();

        // Asynchronous reset mid-RISE at fade_level 0x40
        start_pulse();
        sb_push("pre_rst_fade", 16'h40);
        tick_frames(64);
        sb_check(16'(a_fade));
        #2;
        rst = 1'b1;
        sb_push("arst_fade", 16'd0);
        sb_push("arst_phase", 16'd0);
        sb_push("arst_dir", 16'd0);
        #1;
        sb_check(16'(a_fade));
        sb_check(16'(a_phase));
        sb_check(16'(a_dir));
        cyc();
        rst = 1'b0;
        cyc();

        // Every queued expectation must have been consumed
        total_cnt++;
        assert (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $error("FAIL sb_leftover observed=%0d required=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
